// File: rtl/siso_sched_pkg.sv
// Shared types and helpers for the round-robin SISO frame scheduler.
package siso_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // Bits needed to index n values; never less than one.
   function automatic int clog2w(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first set request after the pointer.
module rr_arbiter
   import siso_sched_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]          req,
   input  logic [clog2w(NREQ)-1:0]  ptr,
   output logic                     valid,
   output logic [clog2w(NREQ)-1:0]  winner
);

   localparam int IW = clog2w(NREQ);

   int unsigned idx;

   // Search ptr+1, ptr+2, ... wrapping modulo NREQ; ptr itself is checked last.
   always_comb begin
      valid  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         idx = (32'(ptr) + i) % NREQ;
         if (!valid && req[idx[IW-1:0]]) begin
            valid  = 1'b1;
            winner = idx[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/siso_frame_sched.sv
// Arbitrates NREQ requesters, serialises the granted word MSB-first onto a
// downstream SISO chain, then flushes DEPTH zeros so the frame leaves it.
module siso_frame_sched
   import siso_sched_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREQ  = 2,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*WIDTH-1:0]    data,
   output logic [NREQ-1:0]          gnt,
   output logic [clog2w(NREQ)-1:0]  gnt_id,
   output logic                     a_in,
   output logic                     shift_en,
   output logic                     busy,
   output logic                     done
);

   localparam int IW = clog2w(NREQ);
   localparam int CW = clog2w(((WIDTH > DEPTH) ? WIDTH : DEPTH) + 1);
   localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
   localparam logic [CW-1:0] LAST_FLUSH = CW'((DEPTH > 0) ? DEPTH - 1 : 0);

   state_t            state, state_nxt;
   logic [WIDTH-1:0]  sreg, word;
   logic [CW-1:0]     cnt;
   logic [IW-1:0]     ptr, winner;
   logic              win_valid;
   logic [NREQ-1:0]   gnt_nxt;
   logic              a_in_nxt, shift_en_nxt, busy_nxt, done_nxt;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req    (req),
      .ptr    (ptr),
      .valid  (win_valid),
      .winner (winner)
   );

   // Mux out the winning requester's word.
   always_comb begin
      word = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (winner == IW'(i)) word = data[i*WIDTH +: WIDTH];
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state: IDLE -> SHIFT for WIDTH cycles -> FLUSH for DEPTH cycles -> IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (win_valid) state_nxt = SHIFT;
         SHIFT:   if (cnt == LAST_BIT) state_nxt = (DEPTH > 0) ? FLUSH : IDLE;
         FLUSH:   if (cnt == LAST_FLUSH) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs, one cycle ahead of the chain.
   always_comb begin
      gnt_nxt      = '0;
      a_in_nxt     = 1'b0;
      shift_en_nxt = 1'b0;
      busy_nxt     = 1'b0;
      done_nxt     = 1'b0;
      case (state)
         IDLE: begin
            if (win_valid) begin
               gnt_nxt[winner] = 1'b1;
               a_in_nxt        = word[WIDTH-1];
               shift_en_nxt    = 1'b1;
               busy_nxt        = 1'b1;
            end
         end
         SHIFT: begin
            if (cnt != LAST_BIT) begin
               a_in_nxt     = sreg[WIDTH-1];
               shift_en_nxt = 1'b1;
               busy_nxt     = 1'b1;
            end else if (DEPTH > 0) begin
               shift_en_nxt = 1'b1;
               busy_nxt     = 1'b1;
            end else begin
               done_nxt     = 1'b1;
            end
         end
         FLUSH: begin
            if (cnt != LAST_FLUSH) begin
               shift_en_nxt = 1'b1;
               busy_nxt     = 1'b1;
            end else begin
               done_nxt     = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Output flops plus datapath; sreg keeps the not-yet-sent bits left-aligned
   // because the MSB is already on a_in when the word is captured.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt      <= '0;
         gnt_id   <= '0;
         a_in     <= 1'b0;
         shift_en <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sreg     <= '0;
         cnt      <= '0;
         ptr      <= IW'(NREQ - 1);
      end else begin
         gnt      <= gnt_nxt;
         a_in     <= a_in_nxt;
         shift_en <= shift_en_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         case (state)
            IDLE: begin
               if (win_valid) begin
                  sreg   <= word << 1;
                  ptr    <= winner;
                  gnt_id <= winner;
                  cnt    <= '0;
               end
            end
            SHIFT: begin
               if (cnt == LAST_BIT) begin
                  cnt <= '0;
               end else begin
                  cnt  <= cnt + CW'(1);
                  sreg <= sreg << 1;
               end
            end
            FLUSH:   cnt <= cnt + CW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_siso_frame_sched.sv
// Bench for siso_frame_sched: a DEPTH=4 and a DEPTH=0 instance, a
// frame-position model checked every cycle, plus directed literal checks.
module tb_siso_frame_sched;

   localparam int W  = 8;
   localparam int NR = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n_a    [2];
   logic [NR-1:0]   req_a      [2];
   logic [NR*W-1:0] data_a     [2];
   logic [NR-1:0]   gnt_a      [2];
   logic            gnt_id_a   [2];
   logic            a_in_a     [2];
   logic            shift_en_a [2];
   logic            busy_a     [2];
   logic            done_a     [2];

   siso_frame_sched #(.WIDTH(W), .NREQ(NR), .DEPTH(4)) u_dut (
      .clk(clk), .rst_n(rst_n_a[0]), .req(req_a[0]), .data(data_a[0]),
      .gnt(gnt_a[0]), .gnt_id(gnt_id_a[0]), .a_in(a_in_a[0]),
      .shift_en(shift_en_a[0]), .busy(busy_a[0]), .done(done_a[0])
   );

   siso_frame_sched #(.WIDTH(W), .NREQ(NR), .DEPTH(0)) u_dut_d0 (
      .clk(clk), .rst_n(rst_n_a[1]), .req(req_a[1]), .data(data_a[1]),
      .gnt(gnt_a[1]), .gnt_id(gnt_id_a[1]), .a_in(a_in_a[1]),
      .shift_en(shift_en_a[1]), .busy(busy_a[1]), .done(done_a[1])
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a frame is a position p counted from the grant cycle (p=0).
   // p<W carries bit W-1-p, W<=p<W+D flushes zeros, p=W+D is the done cycle.
   int          dep    [2] = '{4, 0};
   int          m_pos  [2] = '{-1, -1};
   int          m_ptr  [2] = '{NR-1, NR-1};
   int          m_id   [2] = '{0, 0};
   logic [W-1:0] m_word [2];

   always @(posedge clk) begin
      int k;
      int p;
      logic [6:0] ev, av;
      for (int d = 0; d < 2; d++) begin
         if (!rst_n_a[d]) begin
            m_pos[d] = -1;
            m_ptr[d] = NR - 1;
            m_id[d]  = 0;
         end else if (m_pos[d] < 0 || m_pos[d] == W + dep[d]) begin
            m_pos[d] = -1;
            for (int i = 1; i <= NR; i++) begin
               k = (m_ptr[d] + i) % NR;
               if (m_pos[d] < 0 && req_a[d][k]) begin
                  m_pos[d]  = 0;
                  m_ptr[d]  = k;
                  m_id[d]   = k;
                  m_word[d] = data_a[d][k*W +: W];
               end
            end
         end else begin
            m_pos[d]++;
         end
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         p = m_pos[d];
         ev[6:5] = (p == 0) ? NR'(1 << m_id[d]) : '0;
         ev[4]   = m_id[d][0];
         ev[3]   = (p >= 0 && p < W) ? m_word[d][W-1-p] : 1'b0;
         ev[2]   = (p >= 0 && p < W + dep[d]);
         ev[1]   = (p >= 0 && p < W + dep[d]);
         ev[0]   = (p == W + dep[d]);
         av = {gnt_a[d], gnt_id_a[d], a_in_a[d], shift_en_a[d], busy_a[d], done_a[d]};
         check($sformatf("cycle_dut%0d", d), 32'(av), 32'(ev));
      end
   end

   task automatic reset_dut(input int d);
      @(negedge clk);
      rst_n_a[d] = 1'b0;
      req_a[d]   = '0;
      repeat (2) @(negedge clk);
      rst_n_a[d] = 1'b1;
   endtask

   // Waits (bounded) for a grant, then records the frame; cycle 1 is the gnt cycle.
   task automatic capture(input int d, input bit drop, output logic [7:0] w,
                          output int id, output int busy_n, output int done_at,
                          output int gnt_at);
      int  cyc;
      bit  found;
      cyc   = 0;
      found = 1'b0;
      w       = '0;
      id      = -1;
      busy_n  = 0;
      done_at = 0;
      gnt_at  = 0;
      while (!found && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (gnt_a[d] != '0) found = 1'b1;
      end
      if (!found) begin
         check("gnt_timeout", 32'(cyc), 32'(0));
         return;
      end
      gnt_at = cyc;
      id     = int'(gnt_id_a[d]);
      if (drop) req_a[d] = '0;
      for (int k = 1; k <= 20; k++) begin
         if (k > 1) begin
            @(posedge clk); #1;
         end
         if (k <= W) w = {w[6:0], a_in_a[d]};
         if (busy_a[d]) busy_n++;
         if (done_a[d]) begin
            done_at = k;
            break;
         end
      end
   endtask

   initial begin
      logic [7:0] w;
      int id, bn, dn, ga, prev_dn;
      bit seen;
      for (int d = 0; d < 2; d++) begin
         rst_n_a[d] = 1'b0;
         req_a[d]   = '0;
         data_a[d]  = '0;
      end

      // Reset held with both requests up: outputs stay quiet, then req[0] wins.
      req_a[0]  = 2'b11;
      data_a[0] = 16'h1234;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check("reset_quiet", 32'({gnt_a[0], gnt_id_a[0], a_in_a[0], shift_en_a[0],
                                   busy_a[0], done_a[0]}), 32'(0));
      end
      @(negedge clk);
      rst_n_a[0] = 1'b1;
      rst_n_a[1] = 1'b1;
      @(posedge clk); #1;
      check("release_gnt", 32'(gnt_a[0]), 32'(2'b01));
      check("release_id", 32'(gnt_id_a[0]), 32'(0));

      // Single frame 0xA5.
      reset_dut(0);
      data_a[0] = {8'h00, 8'hA5};
      req_a[0]  = 2'b01;
      capture(0, 1'b1, w, id, bn, dn, ga);
      check("a5_word", 32'(w), 32'h0000_00A5);
      check("a5_id", 32'(id), 32'(0));
      check("a5_busy_cycles", 32'(bn), 32'(12));
      check("a5_done_cycle", 32'(dn), 32'(13));

      // Both held: grants alternate with 13-cycle spacing.
      reset_dut(0);
      data_a[0] = {8'hF0, 8'h0F};
      req_a[0]  = 2'b11;
      prev_dn   = 0;
      for (int k = 0; k < 4; k++) begin
         capture(0, 1'b0, w, id, bn, dn, ga);
         check("alt_id", 32'(id), 32'(k % 2));
         check("alt_word", 32'(w), (k % 2 == 1) ? 32'h0000_00F0 : 32'h0000_000F);
         if (k > 0) check("alt_gap", 32'(prev_dn - 1 + ga), 32'(13));
         prev_dn = dn;
      end
      req_a[0] = '0;

      // Only req[1], then both: req[0] is next in rotation.
      reset_dut(0);
      data_a[0] = {8'h81, 8'h00};
      req_a[0]  = 2'b10;
      capture(0, 1'b1, w, id, bn, dn, ga);
      check("r1_id", 32'(id), 32'(1));
      check("r1_word", 32'(w), 32'h0000_0081);
      req_a[0] = 2'b11;
      capture(0, 1'b1, w, id, bn, dn, ga);
      check("r0_after_r1_id", 32'(id), 32'(0));
      check("r0_after_r1_gap", 32'(ga), 32'(1));

      // Reset during the third SHIFT cycle aborts the frame.
      reset_dut(0);
      data_a[0] = {8'h00, 8'hB4};
      req_a[0]  = 2'b01;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(posedge clk); #1;
         if (gnt_a[0] != '0) seen = 1'b1;
      end
      check("abort_gnt_seen", 32'(seen), 32'(1));
      repeat (2) begin
         @(posedge clk); #1;
      end
      check("abort_bit5", 32'({a_in_a[0], shift_en_a[0], busy_a[0]}), 32'(3'b111));
      #2;
      rst_n_a[0] = 1'b0;
      #1;
      check("abort_async", 32'({a_in_a[0], shift_en_a[0], busy_a[0]}), 32'(0));
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check("abort_no_done", 32'({done_a[0], busy_a[0]}), 32'(0));
      end
      @(negedge clk);
      rst_n_a[0] = 1'b1;
      capture(0, 1'b1, w, id, bn, dn, ga);
      check("restart_word", 32'(w), 32'h0000_00B4);
      check("restart_gap", 32'(ga), 32'(1));
      check("restart_done", 32'(dn), 32'(13));

      // DEPTH=0 instance: done right after the last data bit.
      reset_dut(1);
      data_a[1] = {8'h00, 8'hFF};
      req_a[1]  = 2'b01;
      capture(1, 1'b1, w, id, bn, dn, ga);
      check("d0_word", 32'(w), 32'h0000_00FF);
      check("d0_busy_cycles", 32'(bn), 32'(8));
      check("d0_done_cycle", 32'(dn), 32'(9));

      repeat (3) @(posedge clk);
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/siso_frame_sched.md
Name: siso_frame_sched

Overview:
Round-robin scheduler and serializer that shares one serial-in serial-out shift register chain between NREQ parallel requesters. It arbitrates among requesters and captures the granted WIDTH-bit word. It drives the word MSB-first onto the chain's serial input with a shift enable, then flushes DEPTH zero bits so the last data bit leaves the downstream chain. It sits directly upstream of the SISO shift register and owns its a_in input.

Parameters:
WIDTH, 8, data word width in bits (>=2)
NREQ, 2, number of requesters (2..8)
DEPTH, 4, stage count of downstream SISO chain (flush length, >=0)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  request per requester; held high with data stable until its gnt bit is seen
data  input  NREQ*WIDTH  requester words, requester i at bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot, one-cycle pulse: word of that requester has been captured
gnt_id  output  clog2(NREQ)  index of the current or last granted requester
a_in  output  1  serial bit to the downstream SISO chain
shift_en  output  1  high on every cycle the downstream chain must shift
busy  output  1  high while a frame is in SHIFT or FLUSH
done  output  1  one-cycle pulse when a frame has fully exited the chain

Behaviour:
- Reset (async assert, sync release): state IDLE; gnt, gnt_id, a_in, shift_en, busy, done = 0; rr pointer = NREQ-1, so req[0] wins first; shift register and counters cleared.
- All outputs are registered.
- States: IDLE -> SHIFT -> FLUSH -> IDLE. FLUSH is skipped when DEPTH=0.
- IDLE, at an edge with any req high:
  - Winner is the first set req searching from pointer+1, wrapping modulo NREQ.
  - Load data[winner] into the shift register; pointer = winner; gnt_id = winner.
  - Next cycle: gnt[winner]=1 for exactly one cycle, state SHIFT, bit counter = 0.
- IDLE with no req: outputs idle (a_in=0, shift_en=0); pointer holds.
- SHIFT, WIDTH cycles: a_in = current MSB, shift_en=1, busy=1; register shifts left each cycle. The first cycle (the gnt cycle) carries data bit WIDTH-1; cycle WIDTH carries bit 0.
- FLUSH, DEPTH cycles: a_in=0, shift_en=1, busy=1.
- Exit: next cycle is IDLE with done=1, busy=0, shift_en=0.
- Arbitration may fire at the done cycle's edge, giving back-to-back frames with period 1+WIDTH+DEPTH cycles.
- Latency: req sampled at edge E -> gnt and first data bit in cycle E+1 -> done in cycle E+1+WIDTH+DEPTH.
- req is ignored in SHIFT and FLUSH; req changes there never alter the current frame.
- A requester must drop req on the cycle after its gnt, or it re-enters arbitration. Round-robin fairness then alternates it with others.
- Reset mid-frame: immediate abort, all outputs 0, no done. Pending requests are re-arbitrated from pointer NREQ-1 after release.
- Counters are sized clog2(max(WIDTH,DEPTH)+1); no wrap occurs within a frame.

Decomposition:
- Package siso_sched_pkg: state enum (IDLE, SHIFT, FLUSH) and a clog2-width helper constant function.
- One sub-module, rr_arbiter: combinational round-robin winner select from req and pointer, parameter NREQ, outputs a valid flag and a winner index.
- The FSM, shift register and counters stay in siso_frame_sched.

Test Plan:
- Reset held 3 cycles, req=2'b11 -> all outputs 0 throughout. Release -> gnt=2'b01 one cycle later.
- req[0]=1 with data0=8'hA5, WIDTH=8, DEPTH=4 -> gnt=01 for one cycle. a_in = 1,0,1,0,0,1,0,1 with shift_en=1 over 8 cycles, then 4 zeros with shift_en=1. done=1 in the 13th cycle after the gnt cycle begins; busy=1 for exactly 12 cycles.
- req=2'b11 held continuously, data0=8'h0F, data1=8'hF0 -> grants alternate 0,1,0,1 with gnt_id matching. Successive gnt pulses are 13 cycles apart. Serial streams are 0x0F and 0xF0 MSB-first.
- Only req[1] after reset, data1=8'h81 -> gnt=2'b10, a_in = 1,0,0,0,0,0,0,1. Next req[0]+req[1] -> req[0] granted first.
- rst_n low during the 3rd SHIFT cycle -> a_in, shift_en, busy drop to 0 asynchronously and no done pulses. After release with req[0] still high -> a fresh frame restarts from bit 7.
- DEPTH=0 build, req[0], data0=8'hFF -> 8 ones on a_in, then done in the cycle right after the last bit; no FLUSH cycles.
